// File: rtl/cpu_pkg.sv
// Shared types and field layout for the basic accumulator/MAC CPU.
// No logic of its own; constants only.
// No flow control; consumers are single-cycle datapaths.
package cpu_pkg;

    localparam int PC_W     = 5;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    // Instruction word is n + INSTR_EXTRA bits: {op, rd, rs, imm[n-1:0]}.
    // Offsets below are relative to bit n, so they hold for any data width.
    localparam int INSTR_EXTRA = 13;
    localparam int OP_OFS      = 10;
    localparam int OP_W        = 3;
    localparam int RD_OFS      = 5;
    localparam int RS_OFS      = 0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'b000,
        OP_ACC  = 3'b001,
        OP_ACCI = 3'b010,
        OP_MAC  = 3'b011,
        OP_MACI = 3'b100
    } opcode_e;

    // Adder operand selects: base is either zero or the accumulator,
    // term is either the immediate or the truncated product.
    typedef enum logic {
        BASE_ZERO = 1'b0,
        BASE_ACC  = 1'b1
    } base_sel_e;

    typedef enum logic {
        TERM_IMM  = 1'b0,
        TERM_MULT = 1'b1
    } term_sel_e;

endpackage

// File: rtl/as_alu.sv
// Multiplier, adder and accumulator register for the CPU datapath.
// Product and sum are combinational; the accumulator updates one edge later.
// No backpressure; acc_en simply gates the accumulator load.
module as_alu
    import cpu_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] rd_data,
    input  logic [n-1:0] rs_data,
    input  logic [n-1:0] imm,
    input  logic [8:0]   sw,
    input  base_sel_e    base_sel,
    input  term_sel_e    term_sel,
    input  logic         acc_en,
    output logic [n-1:0] w_data,
    output logic [n-1:0] acc_out
);

    logic        [n-1:0] mult_out;
    logic        [n-1:0] add_out;
    logic        [n-1:0] base;
    logic        [n-1:0] term;
    logic signed [8:0]   sw_s;

    // SW[8] acts as the sign of SW[7:0]; the size cast sign-extends for n > 8
    // and reduces to SW[7:0] when n == 8.
    assign sw_s   = sw;
    assign w_data = n'(sw_s);

    // Low n bits of a product do not depend on operand signedness, so an
    // n-bit multiply gives the signed result truncated to n bits.
    assign mult_out = rd_data * rs_data;

    assign base    = (base_sel == BASE_ACC)  ? acc_out  : '0;
    assign term    = (term_sel == TERM_MULT) ? mult_out : imm;
    assign add_out = base + term;

    // Accumulator loads the adder result whenever the decoder enables it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out <= '0;
        end else if (acc_en) begin
            acc_out <= add_out;
        end
    end

endmodule

// File: rtl/gpr_file.sv
// 32 x n register file: two combinational read ports, one write port.
// Reads are zero-latency; writes land on the next rising edge (reads see old value).
// No backpressure; a write is accepted every cycle we is high.
module gpr_file
    import cpu_pkg::*;
#(
    parameter int n = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [n-1:0]      w_data,
    output logic [n-1:0]      rd_data,
    output logic [n-1:0]      rs_data
);

    logic [n-1:0] gpr [0:NUM_REGS-1];

    assign rd_data = gpr[rd_addr];
    assign rs_data = gpr[rs_addr];

    // Clear every register on reset; otherwise write the rd slot when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (we) begin
            gpr[rd_addr] <= w_data;
        end
    end

endmodule

// File: rtl/basic_cpu.sv
// Single-cycle accumulator/MAC CPU: PC, program ROM, decoder, register file, ALU.
// One instruction per clock; results visible after the following rising edge.
// No backpressure; the PC advances unconditionally every cycle.
module basic_cpu
    import cpu_pkg::*;
#(
    parameter int    n    = 8,
    parameter string PROG = ""
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   SW,
    output logic [n-1:0] LED
);

    localparam int INSTR_W = n + INSTR_EXTRA;

    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr;
    opcode_e            op;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs;
    logic [n-1:0]       imm;

    logic               we;
    logic               acc_en;
    base_sel_e          base_sel;
    term_sel_e          term_sel;

    logic [n-1:0]       rd_data;
    logic [n-1:0]       rs_data;
    logic [n-1:0]       w_data;
    logic [n-1:0]       acc_out;

    function automatic logic [INSTR_W-1:0] enc(opcode_e o, int d, int s, int im);
        logic [31:0] d_v;
        logic [31:0] s_v;
        logic [31:0] im_v;
        d_v  = d;
        s_v  = s;
        im_v = im;
        return {o, d_v[REG_AW-1:0], s_v[REG_AW-1:0], im_v[n-1:0]};
    endfunction

    // Built-in program.
    function automatic logic [INSTR_W-1:0] default_rom(logic [PC_W-1:0] addr);
        case (addr)
            5'd0:    return enc(OP_ACC,   0,  0,  45);
            5'd1:    return enc(OP_ACC,   0,  0, -12);
            5'd2:    return enc(OP_ACCI,  2,  1,   2);
            5'd3:    return enc(OP_ACCI, 23,  1,   3);
            5'd4:    return enc(OP_MACI,  0,  2,   6);
            default: return enc(OP_NOP,   0,  0,   0);
        endcase
    endfunction

    // Combinational fetch from the built-in program.
    always_comb begin
        instr = default_rom(pc_out);
    end

    assign op  = opcode_e'(instr[n+OP_OFS +: OP_W]);
    assign rd  = instr[n+RD_OFS +: REG_AW];
    assign rs  = instr[n+RS_OFS +: REG_AW];
    assign imm = instr[n-1:0];

    // Free-running program counter; wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out <= '0;
        end else begin
            pc_out <= pc_out + 1'b1;
        end
    end

    // Decode the opcode into write/accumulate enables and adder operand selects.
    always_comb begin
        we       = 1'b0;
        acc_en   = 1'b0;
        base_sel = BASE_ZERO;
        term_sel = TERM_IMM;
        case (op)
            OP_ACC: begin
                acc_en = 1'b1;
            end
            OP_ACCI: begin
                acc_en = 1'b1;
                we     = 1'b1;
            end
            OP_MAC: begin
                acc_en   = 1'b1;
                base_sel = BASE_ACC;
                term_sel = TERM_MULT;
            end
            OP_MACI: begin
                acc_en   = 1'b1;
                we       = 1'b1;
                term_sel = TERM_MULT;
            end
            default: begin
                acc_en = 1'b0;
            end
        endcase
    end

    gpr_file #(.n(n)) r0 (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .rd_addr (rd),
        .rs_addr (rs),
        .w_data  (w_data),
        .rd_data (rd_data),
        .rs_data (rs_data)
    );

    as_alu #(.n(n)) as_alu0 (
        .clk      (clk),
        .reset    (reset),
        .rd_data  (rd_data),
        .rs_data  (rs_data),
        .imm      (imm),
        .sw       (SW),
        .base_sel (base_sel),
        .term_sel (term_sel),
        .acc_en   (acc_en),
        .w_data   (w_data),
        .acc_out  (acc_out)
    );

    assign LED = acc_out;

endmodule

// File: tb/tb_basic_cpu.sv
// Self-checking bench for basic_cpu: directed program walk, then random switches
// with occasional asynchronous resets, all checked against a behavioural model.
// Inputs change while clk is low; outputs are sampled 1 time unit after edges.
module tb_basic_cpu;

    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [8:0]   SW    = '0;
    logic [N-1:0] LED;

    basic_cpu #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .SW    (SW),
        .LED   (LED)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: program as a table of (op, rd, rs, imm), op codes
    // 0=nop 1=acc 2=acci 3=mac 4=maci.
    int         p_op  [32];
    int         p_rd  [32];
    int         p_rs  [32];
    int         p_imm [32];
    logic [7:0] m_gpr [32];
    logic [7:0] m_acc;
    int         m_pc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 8'h00;
        m_acc = 8'h00;
        m_pc  = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},  32'(dut.pc_out), 0);
        check({tag, "_acc"}, 32'(dut.as_alu0.acc_out), 0);
        check({tag, "_led"}, 32'(LED), 0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_gpr%0d", tag, i), 32'(dut.r0.gpr[i]), 0);
        end
    endtask

    // Run one instruction with the given switch value. Entered and left with clk low.
    task automatic do_cycle(input logic [8:0] sw);
        int         op;
        logic [7:0] a, b, prod, wd, imm8, exp_add;
        logic [31:0] imm_v;
        SW = sw;
        #1;
        op     = p_op[m_pc];
        a      = m_gpr[p_rd[m_pc]];
        b      = m_gpr[p_rs[m_pc]];
        prod   = a * b;
        wd     = sw[7:0];
        imm_v  = p_imm[m_pc];
        imm8   = imm_v[7:0];
        case (op)
            3:       exp_add = m_acc + prod;
            4:       exp_add = prod;
            default: exp_add = imm8;
        endcase
        check("pc",      32'(dut.pc_out), 32'(m_pc));
        check("w_data",  32'(dut.as_alu0.w_data), 32'(wd));
        check("mult",    32'(dut.as_alu0.mult_out), 32'(prod));
        if (op >= 1 && op <= 4) check("add_out", 32'(dut.as_alu0.add_out), 32'(exp_add));
        @(posedge clk);
        #1;
        if (op >= 1 && op <= 4) m_acc = exp_add;
        if (op == 2 || op == 4) begin
            m_gpr[p_rd[m_pc]] = wd;
            check($sformatf("gpr%0d", p_rd[m_pc]), 32'(dut.r0.gpr[p_rd[m_pc]]), 32'(wd));
        end
        m_pc = (m_pc + 1) % 32;
        check("acc", 32'(dut.as_alu0.acc_out), 32'(m_acc));
        check("led", 32'(LED), 32'(m_acc));
        @(negedge clk);
    endtask

    // Assert reset with clk low and confirm state clears before any edge.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_state(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            p_op[i] = 0; p_rd[i] = 0; p_rs[i] = 0; p_imm[i] = 0;
        end
        p_op[0] = 1; p_imm[0] = 45;
        p_op[1] = 1; p_imm[1] = -12;
        p_op[2] = 2; p_rd[2] = 2;  p_rs[2] = 1; p_imm[2] = 2;
        p_op[3] = 2; p_rd[3] = 23; p_rs[3] = 1; p_imm[3] = 3;
        p_op[4] = 4; p_rd[4] = 0;  p_rs[4] = 2; p_imm[4] = 6;

        reset = 1'b1;
        SW    = '0;
        #12;
        model_reset();
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        // Directed walk through the start of the default program.
        do_cycle(9'd0);
        check("pc0_acc45", 32'(LED), 32'd45);
        do_cycle(9'd0);
        check("pc1_accm12", 32'(LED), 32'h0000_00F4);
        do_cycle(9'd4);
        check("pc2_gpr2", 32'(dut.r0.gpr[2]), 32'd4);
        check("pc2_acc", 32'(LED), 32'd2);
        do_cycle(9'd17);
        check("pc3_gpr23", 32'(dut.r0.gpr[23]), 32'd17);
        check("pc3_acc", 32'(LED), 32'd3);
        do_cycle(9'd17);
        check("pc4_gpr0", 32'(dut.r0.gpr[0]), 32'd17);
        check("pc4_acc", 32'(LED), 32'd0);

        // Finish the first lap; the PC must be back at 0 after 32 clocks.
        for (int i = 5; i < 32; i++) do_cycle(9'($urandom));
        check("pc_wrap", 32'(dut.pc_out), 32'd0);

        // Run into the next lap so registers are non-zero, then reset mid-program.
        for (int i = 0; i < 7; i++) do_cycle(9'($urandom));
        async_reset("mid");

        // Random switches, with an occasional asynchronous reset.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) async_reset("rnd");
            else do_cycle(9'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
